// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: FSM states, opcodes and ALU function codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [3:0] OP_LB    = 4'h2;
  localparam logic [3:0] OP_SB    = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_ANDI  = 4'h6;
  localparam logic [3:0] OP_ORI   = 4'h7;
  localparam logic [3:0] OP_BEQ   = 4'h8;
  localparam logic [3:0] OP_BNE   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_RTYPE = 4'hF;

  localparam logic [2:0] FS_ADD  = 3'b000;
  localparam logic [2:0] FS_SUB  = 3'b001;
  localparam logic [2:0] FS_AND  = 3'b010;
  localparam logic [2:0] FS_OR   = 3'b011;
  localparam logic [2:0] FS_XOR  = 3'b100;
  localparam logic [2:0] FS_SLL1 = 3'b101;
  localparam logic [2:0] FS_SRL1 = 3'b110;
  localparam logic [2:0] FS_PASS = 3'b111;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/alu_p.sv
// Combinational ALU; all results wrap to DATA_W bits.
module alu_p import cpu_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        fs,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = a;
    case (fs)
      FS_ADD:  y = a + b;
      FS_SUB:  y = a - b;
      FS_AND:  y = a & b;
      FS_OR:   y = a | b;
      FS_XOR:  y = a ^ b;
      FS_SLL1: y = a << 1;
      FS_SRL1: y = a >> 1;
      FS_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle CPU: FETCH/DECODE/EXEC/(MEM)/WB with stallable instruction and data ports.
// Handshake: IREQ/DREQ stay high in their state until IRDY/DRDY is seen high at a rising CLK.
module multicycle_cpu import cpu_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN_L,
  output logic              IREQ,
  output logic [PC_W-1:0]   IADDR,
  input  logic              IRDY,
  input  logic [15:0]       Iin,
  output logic              DREQ,
  output logic              MW,
  output logic [DATA_W-1:0] DADDR,
  output logic [DATA_W-1:0] DOUT,
  input  logic              DRDY,
  input  logic [DATA_W-1:0] Din,
  output logic [PC_W-1:0]   PC,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB,
  output logic [DATA_W-1:0] DataC,
  output logic [2:0]        STATE
);

  state_t              state_q, state_d;
  logic [15:0]         ir_q;
  logic [DATA_W-1:0]   a_q, b_q, mdr_q;
  logic [DATA_W-1:0]   rf_q [8];
  logic [PC_W-1:0]     pc_q, pc_next, pc_inc;
  logic [3:0]          op;
  logic [DATA_W-1:0]   imm_d, alu_b, alu_y, wb_val;
  logic [PC_W-1:0]     imm_pc;
  logic [2:0]          alu_fs, wr_addr;
  logic                wr_en;

  assign op     = ir_q[15:12];
  assign imm_d  = DATA_W'($signed(ir_q[5:0]));
  assign imm_pc = PC_W'($signed(ir_q[5:0]));
  assign pc_inc = pc_q + PC_W'(2);
  assign wb_val = (op == OP_LB) ? mdr_q : alu_y;

  // Immediate forms reuse the ALU with the sign-extended immediate as operand B.
  always_comb begin
    alu_b   = b_q;
    alu_fs  = ir_q[2:0];
    wr_en   = 1'b0;
    wr_addr = ir_q[8:6];
    pc_next = pc_inc;
    case (op)
      OP_RTYPE: begin wr_en = 1'b1; wr_addr = ir_q[5:3]; end
      OP_ADDI:  begin alu_b = imm_d; alu_fs = FS_ADD; wr_en = 1'b1; end
      OP_ANDI:  begin alu_b = imm_d; alu_fs = FS_AND; wr_en = 1'b1; end
      OP_ORI:   begin alu_b = imm_d; alu_fs = FS_OR;  wr_en = 1'b1; end
      OP_LB:    wr_en = 1'b1;
      OP_BEQ:   if (a_q == b_q) pc_next = pc_inc + (imm_pc << 1);
      OP_BNE:   if (a_q != b_q) pc_next = pc_inc + (imm_pc << 1);
      OP_JMP:   pc_next = PC_W'({ir_q[11:0], 1'b0});
      default:  ;
    endcase
  end

  alu_p #(.DATA_W(DATA_W)) u_alu (
    .a  (a_q),
    .b  (alu_b),
    .fs (alu_fs),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    IREQ    = 1'b0;
    DREQ    = 1'b0;
    MW      = 1'b0;
    DataC   = '0;
    case (state_q)
      ST_FETCH: begin
        IREQ = 1'b1;
        if (IRDY) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = is_mem_op(op) ? ST_MEM : ST_WB;
      ST_MEM: begin
        DREQ = 1'b1;
        MW   = (op == OP_SB);
        if (DRDY) state_d = ST_WB;
      end
      ST_WB: begin
        DataC   = wb_val;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // EN_L high holds every register, so outputs decoded from state stay put too.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (!EN_L) begin
      state_q <= state_d;
      case (state_q)
        ST_FETCH:  if (IRDY) ir_q <= Iin;
        ST_DECODE: begin
          a_q <= rf_q[ir_q[11:9]];
          b_q <= rf_q[ir_q[8:6]];
        end
        ST_MEM:    if (DRDY) mdr_q <= Din;
        ST_WB: begin
          if (wr_en) rf_q[wr_addr] <= wb_val;
          pc_q <= pc_next;
        end
        default: ;
      endcase
    end
  end

  assign IADDR = pc_q;
  assign PC    = pc_q;
  assign DADDR = a_q + imm_d;
  assign DOUT  = b_q;
  assign DataA = a_q;
  assign DataB = b_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: instruction-level reference model with a per-cycle compare process.
module tb_multicycle_cpu;

  logic        CLK, RESET, EN_L, IREQ, IRDY, DREQ, MW, DRDY;
  logic [7:0]  IADDR, DADDR, DOUT, Din, PC, DataA, DataB, DataC;
  logic [15:0] Iin;
  logic [2:0]  STATE;

  multicycle_cpu #(.DATA_W(8), .PC_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .EN_L(EN_L),
    .IREQ(IREQ), .IADDR(IADDR), .IRDY(IRDY), .Iin(Iin),
    .DREQ(DREQ), .MW(MW), .DADDR(DADDR), .DOUT(DOUT), .DRDY(DRDY), .Din(Din),
    .PC(PC), .DataA(DataA), .DataB(DataB), .DataC(DataC), .STATE(STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // ---------------- architectural model ----------------
  logic [7:0] m_rf [8];
  logic [7:0] m_pc;
  logic [7:0] dmem [256];

  int         exp_st;
  logic [7:0] exp_a, exp_b, exp_datac, exp_daddr, exp_dout;
  bit         exp_dc_valid, exp_mw, chk_en, frz_ok;
  int         n_checks = 0, n_pass = 0, dreq_cycles = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Architectural effect of one instruction, from the ISA rules.
  function automatic void model(input logic [15:0] ins, input logic [7:0] a, b, pc, din,
                                output bit we, output int widx, output logic [7:0] wval,
                                output logic [7:0] npc);
    int imm, ai, bi, r, j;
    imm = int'(ins[5:0]);
    if (imm > 31) imm -= 64;
    ai = int'(a); bi = int'(b); r = 0; we = 0; widx = 0;
    npc = 8'((int'(pc) + 2) & 255);
    case (ins[15:12])
      4'hF: begin
        case (ins[2:0])
          3'd0: r = ai + bi;
          3'd1: r = ai - bi;
          3'd2: r = ai & bi;
          3'd3: r = ai | bi;
          3'd4: r = ai ^ bi;
          3'd5: r = ai * 2;
          3'd6: r = ai / 2;
          default: r = ai;
        endcase
        we = 1; widx = int'(ins[5:3]);
      end
      4'h2: begin r = int'(din);         we = 1; widx = int'(ins[8:6]); end
      4'h5: begin r = ai + imm;          we = 1; widx = int'(ins[8:6]); end
      4'h6: begin r = ai & (imm & 255);  we = 1; widx = int'(ins[8:6]); end
      4'h7: begin r = ai | (imm & 255);  we = 1; widx = int'(ins[8:6]); end
      4'h8: if (ai == bi) npc = 8'((int'(pc) + 2 + imm * 2) & 255);
      4'h9: if (ai != bi) npc = 8'((int'(pc) + 2 + imm * 2) & 255);
      4'hA: begin j = int'(ins[11:0]); npc = 8'((j * 2) & 255); end
      default: ;
    endcase
    wval = 8'(r & 255);
  endfunction

  function automatic logic [15:0] itype(input int op, input int rs, input int rt, input int imm);
    return {4'(op), 3'(rs), 3'(rt), 6'(imm)};
  endfunction

  function automatic logic [15:0] rtype(input int rs, input int rt, input int rd, input int fs);
    return {4'hF, 3'(rs), 3'(rt), 3'(rd), 3'(fs)};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      if (DREQ) dreq_cycles++;
      check("state",  32'(STATE), 32'(exp_st));
      check("pc",     32'(PC), 32'(m_pc));
      check("ireq",   32'(IREQ), 32'(exp_st == 0));
      check("dreq",   32'(DREQ), 32'(exp_st == 3));
      check("mw",     32'(MW), 32'(exp_st == 3 && exp_mw));
      check("data_a", 32'(DataA), 32'(exp_a));
      check("data_b", 32'(DataB), 32'(exp_b));
      if (exp_st == 0) check("iaddr", 32'(IADDR), 32'(m_pc));
      if (exp_st == 3) begin
        check("daddr", 32'(DADDR), 32'(exp_daddr));
        check("dout",  32'(DOUT), 32'(exp_dout));
      end
      if (exp_st != 4) check("data_c_idle", 32'(DataC), 32'h0);
      else if (exp_dc_valid) check("data_c_wb", 32'(DataC), 32'(exp_datac));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    logic sv_i, sv_d;
    if (frz_ok && $urandom_range(0, 9) == 0) begin
      sv_i = IRDY; sv_d = DRDY;
      EN_L = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        IRDY = 1'($urandom); DRDY = 1'($urandom);
        @(posedge CLK); #1;
      end
      IRDY = sv_i; DRDY = sv_d; EN_L = 1'b0;
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; EN_L = 1'($urandom); IRDY = 1'b0; DRDY = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0; EN_L = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h0;
    m_pc = 8'h0; exp_st = 0; exp_a = 8'h0; exp_b = 8'h0;
    exp_dc_valid = 0; exp_mw = 0; chk_en = 1;
  endtask

  task automatic run_instr(input logic [15:0] ins, input int iw, input int dw,
                           input int frz_exec, input bit rst_mem);
    logic [7:0] a, b, addr, din, wval, npc;
    logic [3:0] op;
    bit we;
    int widx, imm;
    op = ins[15:12];
    a = m_rf[ins[11:9]]; b = m_rf[ins[8:6]];
    imm = int'(ins[5:0]);
    if (imm > 31) imm -= 64;
    addr = 8'((int'(a) + imm) & 255);
    din = dmem[addr];
    model(ins, a, b, m_pc, din, we, widx, wval, npc);
    repeat (iw) begin IRDY = 1'b0; Iin = 16'($urandom); step(); end
    IRDY = 1'b1; Iin = ins; step();
    IRDY = 1'b0; Iin = 16'($urandom); exp_st = 1;
    step(); exp_st = 2; exp_a = a; exp_b = b;
    if (frz_exec > 0) begin
      EN_L = 1'b1;
      repeat (frz_exec) begin
        IRDY = 1'($urandom); DRDY = 1'($urandom); Din = 8'($urandom);
        @(posedge CLK); #1;
      end
      EN_L = 1'b0; IRDY = 1'b0; DRDY = 1'b0;
    end
    if (op == 4'h2 || op == 4'h4) begin
      step(); exp_st = 3; exp_daddr = addr; exp_dout = b; exp_mw = (op == 4'h4);
      if (rst_mem) begin
        repeat (2) step();
        do_reset();
        return;
      end
      repeat (dw) begin DRDY = 1'b0; step(); end
      DRDY = 1'b1; Din = din; step();
      DRDY = 1'b0; Din = 8'($urandom);
    end else begin
      step();
    end
    exp_st = 4; exp_datac = wval; exp_dc_valid = we;
    step();
    if (we) m_rf[widx] = wval;
    m_pc = npc;
    if (op == 4'h4) dmem[addr] = b;
    exp_st = 0; exp_dc_valid = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    logic [15:0] ins;
    chk_en = 0; frz_ok = 0;
    RESET = 1'b0; EN_L = 1'b0; IRDY = 1'b0; DRDY = 1'b0; Iin = 16'h0; Din = 8'h0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
    repeat (2) @(posedge CLK);
    #1;
    do_reset();
    check("rst_state", 32'(STATE), 32'h0);
    check("rst_pc",    32'(PC), 32'h0);
    check("rst_ireq",  32'(IREQ), 32'h1);

    // ADDI R1,R0,5 ; ADDI R2,R0,-3 ; ADD R3=R1+R2
    c0 = cyc;
    run_instr(itype(5, 0, 1, 5), 0, 0, 0, 0);
    run_instr(itype(5, 0, 2, 6'h3D), 0, 0, 0, 0);
    run_instr(rtype(1, 2, 3, 0), 0, 0, 0, 0);
    check("seq_cycles", 32'(cyc - c0), 32'd12);
    check("seq_pc",     32'(PC), 32'h06);
    check("seq_r3_mdl", 32'(m_rf[3]), 32'h02);
    run_instr(rtype(3, 0, 7, 7), 0, 0, 0, 0);
    check("seq_r3",     32'(DataA), 32'h02);

    // SB R1 -> [R0+4] with 3 wait states, then LB R4 from there
    dreq_cycles = 0;
    run_instr(itype(4, 0, 1, 4), 0, 3, 0, 0);
    check("sb_dreq_cycles", 32'(dreq_cycles), 32'd4);
    check("sb_mem",         32'(dmem[4]), 32'h05);
    run_instr(itype(2, 0, 4, 4), 1, 1, 0, 0);
    run_instr(rtype(4, 0, 7, 7), 0, 0, 0, 0);
    check("lb_r4", 32'(DataA), 32'h05);

    // Branches at 0x10
    run_instr({4'hA, 12'h008}, 0, 0, 0, 0);
    check("jmp_10", 32'(PC), 32'h10);
    run_instr(itype(8, 1, 1, 6'h3E), 0, 0, 0, 0);
    check("beq_taken", 32'(PC), 32'h0E);
    run_instr({4'hA, 12'h008}, 0, 0, 0, 0);
    run_instr(itype(9, 1, 1, 6'h3E), 0, 0, 0, 0);
    check("bne_not_taken", 32'(PC), 32'h12);

    // JMP truncation and PC wrap
    run_instr({4'hA, 12'h0FF}, 0, 0, 0, 0);
    check("jmp_fe", 32'(PC), 32'hFE);
    run_instr(itype(5, 1, 5, 1), 0, 0, 0, 0);
    check("pc_wrap", 32'(PC), 32'h00);

    // Freeze for 5 cycles in EXEC
    run_instr(rtype(1, 5, 6, 0), 0, 0, 5, 0);
    check("frz_pc", 32'(PC), 32'h02);
    run_instr(rtype(6, 0, 7, 7), 0, 0, 0, 0);
    check("frz_r6", 32'(DataA), 32'h0B);

    // Reset while a load is pending in MEM
    run_instr(itype(2, 1, 5, 0), 0, 0, 0, 1);
    check("rst_mem_dreq",  32'(DREQ), 32'h0);
    check("rst_mem_pc",    32'(PC), 32'h0);
    check("rst_mem_state", 32'(STATE), 32'h0);
    run_instr(rtype(5, 0, 7, 7), 0, 0, 0, 0);
    check("rst_mem_r5", 32'(DataA), 32'h0);

    // Randomized programs with wait states, freezes and occasional resets
    frz_ok = 1;
    repeat (200) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      if ($urandom_range(0, 2) == 0)
        ins = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      else
        ins = itype($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
    end
    frz_ok = 0;
    repeat (2) @(posedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning datapath and register width (>=8).
REQ-002 SHALL have parameter PC_W, default 8, meaning program counter width (>=4).
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port EN_L  input  1  active-low run enable; high freezes state, registers and PC.
REQ-006 SHALL have ports IREQ out 1, IADDR out PC_W, IRDY in 1, Iin in 16: instruction fetch request, address, data-valid, instruction word.
REQ-007 SHALL have ports DREQ out 1, MW out 1, DADDR out DATA_W, DOUT out DATA_W, DRDY in 1, Din in DATA_W: data-memory request, write strobe, address, write data, completion, read data.
REQ-008 SHALL have ports PC out PC_W, DataA out DATA_W, DataB out DATA_W, DataC out DATA_W, STATE out 3: debug taps (current PC, register read ports, write-back value, FSM state).

Function
REQ-009 SHALL run FSM FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH, one state per cycle except where stalled.
REQ-010 FETCH SHALL hold IREQ=1, IADDR=PC until IRDY=1, then latch Iin into IR and go to DECODE; any number of wait cycles allowed.
REQ-011 DECODE SHALL latch R[Iin[11:9]] into A and R[Iin[8:6]] into B; DataA/DataB SHALL show A/B.
REQ-012 Opcode map on IR[15:12]: 0xF R-type (DR=IR[5:3], FS=IR[2:0]); 0x2 LB; 0x4 SB; 0x5 ADDI; 0x6 ANDI; 0x7 ORI; 0x8 BEQ; 0x9 BNE; 0xA JMP; all others NOP (no register or memory write).
REQ-013 FS codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL1, 110 SRL1, 111 PASS A; results truncated to DATA_W, carries discarded.
REQ-014 Immediate forms SHALL use imm6=IR[5:0] sign-extended to DATA_W; ANDI/ORI/ADDI write DR=IR[8:6].
REQ-015 LB: DADDR=A+sext(imm6), DREQ=1, MW=0 held in MEM until DRDY=1; Din captured that cycle and written to R[IR[8:6]] in WB.
REQ-016 SB: DADDR=A+sext(imm6), DOUT=B, DREQ=1, MW=1 held in MEM until DRDY=1; no register write.
REQ-017 DREQ and MW SHALL be 0 in all states other than MEM.
REQ-018 Default next PC SHALL be PC+2 modulo 2^PC_W, applied in WB.
REQ-019 BEQ/BNE: when (A==B) resp. (A!=B), next PC = PC+2+(sext(imm6)<<1) modulo 2^PC_W; otherwise PC+2.
REQ-020 JMP: next PC = {IR[11:0],1'b0} truncated/zero-extended to PC_W.
REQ-021 Register file SHALL be 8 x DATA_W, written only in WB, one write per instruction; R0 is an ordinary register.
REQ-022 DataC SHALL show write-back value in WB (Din for LB, ALU result otherwise), 0 in other states.
REQ-023 EN_L=1 SHALL freeze FSM, PC, IR, A, B and registers; IREQ/DREQ held at their current values so an open transaction remains pending.
REQ-024 Each instruction SHALL take 4 cycles (non-memory) or 5 cycles (LB/SB) with zero wait states.

Reset
REQ-025 RESET=1 at a rising edge SHALL set PC=0, state=FETCH, IR=0, A=B=0 and all 8 registers=0, overriding EN_L.
REQ-026 During and after reset: IREQ=1 (FETCH), DREQ=0, MW=0, DataC=0, STATE=FETCH encoding 0.
REQ-027 RESET during a pending MEM or FETCH transaction SHALL abandon it; no register or PC update from it.

Structure
REQ-028 Opcode, FS and state encodings SHALL live in shared package cpu_pkg.
REQ-029 ALU SHALL be sub-module alu_p, parametrised by DATA_W, purely combinational.

Verification
REQ-030 ADDI R1,R0,5 then ADDI R2,R0,-3 then R-type ADD R3=R1+R2, DATA_W=8 -> R3=0x02, PC=6 after 12 cycles.
REQ-031 SB R1 to [R0+4] with DRDY delayed 3 cycles -> DREQ/MW high exactly 4 cycles, DADDR=4, DOUT=5, then LB R4 from same address returns 5.
REQ-032 BEQ R1,R1,imm6=-2 at PC=0x10 -> next PC=0x0E; BNE same operands -> PC=0x12.
REQ-033 PC_W=8, JMP at PC=0xFE with IR[11:0]=0x0FF -> PC=0xFE; ADDI at PC=0xFE -> PC wraps to 0x00.
REQ-034 Raise EN_L mid-EXEC for 5 cycles -> STATE, PC, registers unchanged; resumes identically after EN_L=0.
REQ-035 Assert RESET while in MEM with DREQ=1 -> next cycle DREQ=0, PC=0, STATE=FETCH, target register unchanged-at-zero.
